// File: rtl/mem_pkg.sv
// Shared constants and address decode for the memory responder.
// Decode is pure combinational; no latency or flow control at package level.
package mem_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [31:0] IO_OUT_OFS    = 32'h0000_0000;
    localparam logic [31:0] CYCLE_CNT_OFS = 32'h0000_0004;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_UNMAPPED = 2'd2;

    localparam logic [1:0] TGT_NONE   = 2'd0;
    localparam logic [1:0] TGT_RAM    = 2'd1;
    localparam logic [1:0] TGT_IO_OUT = 2'd2;
    localparam logic [1:0] TGT_CYCLE  = 2'd3;

    typedef struct packed {
        logic [1:0] tgt;
        logic [1:0] fault;
    } decode_t;

    // A faulting access always reports TGT_NONE so nothing downstream acts on it.
    function automatic decode_t decode_adr(input logic [31:0] adr,
                                           input logic [31:0] ram_bytes,
                                           input logic [31:0] io_base);
        decode_t d;
        d.tgt   = TGT_NONE;
        d.fault = FAULT_NONE;
        if (adr[1:0] != 2'b00)
            d.fault = FAULT_MISALIGN;
        else if (adr < ram_bytes)
            d.tgt = TGT_RAM;
        else if (adr == io_base + IO_OUT_OFS)
            d.tgt = TGT_IO_OUT;
        else if (adr == io_base + CYCLE_CNT_OFS)
            d.tgt = TGT_CYCLE;
        else
            d.fault = FAULT_UNMAPPED;
        return d;
    endfunction

endpackage

// File: rtl/mem_ram.sv
// Single-port synchronous word RAM, contents not reset.
// Read data appears one cycle after rd_en; writes take effect at the edge; no backpressure.
module mem_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wr_dat,
    output logic [31:0]   rd_dat
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[addr] <= wr_dat;
        else if (rd_en)
            rd_dat <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: word RAM plus IO_OUT / CYCLE_CNT registers with fault reporting.
// MemReady pulses LATENCY+1 cycles after accept; requests outside IDLE are ignored, never queued.
module mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr,
    output logic [31:0] io_out
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LAT       = 4'(LATENCY);

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic [31:0] adr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [1:0]  tgt_q;
    logic        err_q;
    logic        rsp_from_ram_q;
    logic [31:0] rsp_dat_q;
    logic [31:0] io_out_q;
    logic [31:0] cycle_cnt;

    logic [31:0] eff_adr;
    decode_t     dec;
    logic        dec_err;
    logic        accept;
    logic        enter_resp;
    logic        commit;
    logic        ram_rd_en;
    logic        ram_wr_en;
    logic [31:0] ram_rd_dat;

    // With zero wait states the response is captured on the accept edge, so the
    // live address must be decoded instead of the not-yet-latched copy.
    always_comb begin
        eff_adr    = (state == S_IDLE) ? Adr : adr_q;
        dec        = decode_adr(eff_adr, RAM_BYTES, IO_BASE);
        dec_err    = (dec.fault != FAULT_NONE);
        accept     = (state == S_IDLE) && MemReq;
        enter_resp = (accept && (LAT == 4'd0)) ||
                     ((state == S_WAIT) && (wait_cnt == 4'd1));
        commit     = (state == S_RESP) && we_q && !err_q && !reset;
        ram_rd_en  = enter_resp && (dec.tgt == TGT_RAM) && !reset;
        ram_wr_en  = commit && (tgt_q == TGT_RAM);
    end

    mem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk   (clk),
        .rd_en (ram_rd_en),
        .wr_en (ram_wr_en),
        .addr  (eff_adr[AW+1:2]),
        .wr_dat(wdata_q),
        .rd_dat(ram_rd_dat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            adr_q    <= 32'd0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (MemReq) begin
                        adr_q    <= Adr;
                        wdata_q  <= WriteData;
                        we_q     <= MemWrite;
                        wait_cnt <= LAT;
                        state    <= (LAT == 4'd0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1)
                        state <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Response payload is frozen on the edge entering RESP and held through IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_q          <= TGT_NONE;
            err_q          <= 1'b0;
            rsp_from_ram_q <= 1'b0;
            rsp_dat_q      <= 32'd0;
        end else if (enter_resp) begin
            tgt_q          <= dec.tgt;
            err_q          <= dec_err;
            rsp_from_ram_q <= (dec.tgt == TGT_RAM);
            case (dec.tgt)
                TGT_IO_OUT: rsp_dat_q <= io_out_q;
                TGT_CYCLE:  rsp_dat_q <= cycle_cnt;
                default:    rsp_dat_q <= 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            io_out_q <= 32'd0;
        else if (commit && (tgt_q == TGT_IO_OUT))
            io_out_q <= wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cycle_cnt <= 32'd0;
        else
            cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign ReadData = rsp_from_ram_q ? ram_rd_dat : rsp_dat_q;
    assign MemReady = (state == S_RESP);
    assign MemErr   = (state == S_RESP) && err_q;
    assign io_out   = io_out_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 0, 1, 3) driven by directed and random accesses.
module tb_mem_responder;

    localparam int          DEPTH   = 64;
    localparam logic [31:0] IO_BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [3];
    logic        req [3];
    logic        wr  [3];
    logic [31:0] adr [3];
    logic [31:0] wd  [3];
    logic [31:0] rd  [3];
    logic [31:0] io  [3];
    logic        rdy [3];
    logic        err [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .DEPTH_WORDS(DEPTH),
            .LATENCY    ((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
            .IO_BASE    (IO_BASE)
        ) u_dut (
            .clk      (clk),
            .reset    (rst[g]),
            .MemReq   (req[g]),
            .MemWrite (wr[g]),
            .Adr      (adr[g]),
            .WriteData(wd[g]),
            .ReadData (rd[g]),
            .MemReady (rdy[g]),
            .MemErr   (err[g]),
            .io_out   (io[g])
        );
    end

    int          total = 0;
    int          bad   = 0;
    int unsigned edge_no = 0;
    always @(posedge clk) edge_no++;

    // Reference model: word store, IO_OUT shadow, and last observed CYCLE_CNT sample.
    logic [31:0] mem_m    [3][DEPTH];
    bit          known    [3][DEPTH];
    logic [31:0] io_m     [3];
    bit          cnt_ok   [3];
    logic [31:0] last_cnt [3];
    int unsigned last_acc [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts and ends on a falling edge; returns on the response cycle (or after 40 cycles).
    task automatic xact(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] r, output logic e, output int n, output int unsigned acc);
        req[i] = 1'b1;
        wr[i]  = w;
        adr[i] = a;
        wd[i]  = d;
        step();
        acc    = edge_no;
        req[i] = 1'b0;
        n      = 1;
        while (rdy[i] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        r = rd[i];
        e = err[i];
    endtask

    task automatic do_op(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic        e;
        int          n;
        int unsigned acc;
        bit          is_ram;
        bit          flt;
        int          wi;
        logic [31:0] io_before;
        is_ram    = (a < 32'(DEPTH * 4));
        wi        = is_ram ? int'(a >> 2) : 0;
        flt       = (a % 4 != 0) || !(is_ram || a == IO_BASE || a == IO_BASE + 32'd4);
        io_before = io_m[i];
        xact(i, w, a, d, r, e, n, acc);
        chk("latency", 32'(n), 32'(lat_of(i) + 1));
        chk("mem_err", 32'(e), 32'(flt));
        chk("io_out_at_resp", io[i], io_before);
        if (!w) begin
            if (flt)
                chk("fault_rdata", r, 32'd0);
            else if (is_ram) begin
                if (known[i][wi]) chk("ram_rdata", r, mem_m[i][wi]);
            end else if (a == IO_BASE)
                chk("io_rdata", r, io_m[i]);
            else begin
                if (cnt_ok[i]) chk("cnt_rdata", r, last_cnt[i] + 32'(acc - last_acc[i]));
                last_cnt[i] = r;
                last_acc[i] = acc;
                cnt_ok[i]   = 1'b1;
            end
        end else if (!flt) begin
            if (is_ram) begin
                mem_m[i][wi] = d;
                known[i][wi] = 1'b1;
            end else if (a == IO_BASE)
                io_m[i] = d;
        end
        step();
        chk("ready_single_pulse", 32'(rdy[i]), 32'd0);
        chk("io_out_after", io[i], io_m[i]);
    endtask

    initial begin
        int          first;
        int          pulses;
        logic [31:0] hold_rd;
        logic [31:0] r1;
        logic [31:0] r2;
        int unsigned acc1;
        bit          saw_rdy;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; wr[i] = 1'b0; adr[i] = 32'd0; wd[i] = 32'd0;
            io_m[i] = 32'd0; cnt_ok[i] = 1'b0; last_cnt[i] = 32'd0; last_acc[i] = 0;
            for (int k = 0; k < DEPTH; k++) begin
                known[i][k] = 1'b0;
                mem_m[i][k] = 32'd0;
            end
        end
        repeat (3) step();
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("reset_ready", 32'(rdy[i]), 32'd0);
            chk("reset_err", 32'(err[i]), 32'd0);
            chk("reset_rdata", rd[i], 32'd0);
            chk("reset_io_out", io[i], 32'd0);
        end

        // RAM write then read, one wait state
        do_op(1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        do_op(1, 1'b0, 32'h10, 32'h0);
        chk("deadbeef_rdata", rd[1], 32'hDEAD_BEEF);

        // Zero and three wait states
        do_op(0, 1'b1, 32'h0, 32'h1234_5678);
        do_op(0, 1'b0, 32'h0, 32'h0);
        do_op(2, 1'b1, 32'h0, 32'h1234_5678);
        do_op(2, 1'b0, 32'h0, 32'h0);

        // MemReq held high through WAIT must yield exactly one response
        first = -1; pulses = 0; hold_rd = 32'd0;
        req[2] = 1'b1; wr[2] = 1'b0; adr[2] = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (rdy[2] === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first   = k;
                    hold_rd = rd[2];
                end
            end
            if (k == 4) req[2] = 1'b0;
        end
        chk("hold_pulse_count", 32'(pulses), 32'd1);
        chk("hold_latency", 32'(first), 32'd4);
        chk("hold_rdata", hold_rd, 32'h1234_5678);

        // Faults leave RAM untouched
        do_op(1, 1'b0, 32'h12, 32'h0);
        do_op(1, 1'b0, 32'h1000, 32'h0);
        do_op(1, 1'b1, 32'h12, 32'h0BAD_0BAD);
        do_op(1, 1'b1, 32'h1000, 32'h0BAD_0BAD);
        do_op(1, 1'b0, 32'h10, 32'h0);

        // IO_OUT write/readback
        do_op(1, 1'b1, IO_BASE, 32'h0000_00A5);
        do_op(1, 1'b0, IO_BASE, 32'h0);
        chk("io_a5", io[1], 32'h0000_00A5);

        // CYCLE_CNT sampled twice, accepts 10 cycles apart
        req[1] = 1'b1; wr[1] = 1'b0; adr[1] = IO_BASE + 32'd4;
        step();
        acc1 = edge_no;
        req[1] = 1'b0;
        r1 = 32'd0; r2 = 32'd0;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 1) begin
                chk("cnt_rdy1", 32'(rdy[1]), 32'd1);
                r1 = rd[1];
            end
            if (k == 9) req[1] = 1'b1;
            if (k == 10) req[1] = 1'b0;
            if (k == 11) begin
                chk("cnt_rdy2", 32'(rdy[1]), 32'd1);
                r2 = rd[1];
            end
        end
        chk("cnt_delta", r2 - r1, 32'd10);
        last_cnt[1] = r2; last_acc[1] = acc1 + 10; cnt_ok[1] = 1'b1;
        step();
        do_op(1, 1'b1, IO_BASE + 32'd4, 32'hFFFF_FFFF);
        do_op(1, 1'b0, IO_BASE + 32'd4, 32'h0);

        // Reset during the second WAIT cycle of a write
        do_op(2, 1'b1, 32'h20, 32'h1111_1111);
        do_op(2, 1'b1, IO_BASE, 32'h0000_003C);
        req[2] = 1'b1; wr[2] = 1'b1; adr[2] = 32'h20; wd[2] = 32'h55;
        step();
        req[2] = 1'b0;
        step();
        rst[2] = 1'b1;
        saw_rdy = (rdy[2] === 1'b1);
        step();
        rst[2] = 1'b0;
        io_m[2] = 32'd0; cnt_ok[2] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (rdy[2] === 1'b1) saw_rdy = 1'b1;
            step();
        end
        chk("rst_wait_no_ready", 32'(saw_rdy), 32'd0);
        chk("rst_wait_io_out", io[2], 32'd0);
        chk("rst_wait_rdata", rd[2], 32'd0);
        do_op(2, 1'b0, 32'h20, 32'h0);
        chk("rst_wait_ram_kept", rd[2], 32'h1111_1111);

        // Randomized traffic against the model
        for (int t = 0; t < 80; t++) begin
            int          i;
            int          kind;
            logic        w;
            logic [31:0] a;
            i    = $urandom_range(0, 2);
            kind = $urandom_range(0, 9);
            w    = 1'($urandom_range(0, 1));
            case (kind)
                5:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                6:       a = 32'h100 + (32'($urandom_range(0, 1000)) << 2);
                7:       a = IO_BASE;
                8:       a = IO_BASE + 32'd4;
                9:       a = IO_BASE + 32'd8 + (32'($urandom_range(0, 50)) << 2);
                default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            endcase
            if (kind < 5 && !known[i][int'(a >> 2)]) w = 1'b1;
            do_op(i, w, a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
